// File: rtl/cr_gen_fifo_disp_if.sv
// Bus bundle for cr_gen_fifo_disp: generator/reader enables in,
// FIFO status, last popped word and 7-seg drive out.
interface cr_gen_fifo_disp_if #(
    parameter int DW     = 8,
    parameter int DEPTH  = 8,
    parameter int DIGITS = 4
);
    logic                     ENgen;
    logic                     ENraf;
    logic [$clog2(DEPTH):0]   usedw;
    logic                     full;
    logic                     empty;
    logic [DW-1:0]            rd_data;
    logic [6:0]               ss;
    logic [DIGITS:1]          dig;
    logic                     ovf;

    modport master (
        output ENgen, ENraf,
        input  usedw, full, empty, rd_data, ss, dig, ovf
    );

    modport slave (
        input  ENgen, ENraf,
        output usedw, full, empty, rd_data, ss, dig, ovf
    );
endinterface

// File: rtl/cr_gen_fifo_disp.sv
// Counter generator -> FIFO -> tick-paced reader -> muxed hex 7-seg display.
// Optional sticky overflow flag built only when CR_OVF_LATCH_EN is defined.
module cr_gen_fifo_disp #(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 8_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int DIGITS   = 4
) (
    input logic              CLK,
    input logic              RST,
    cr_gen_fifo_disp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NW = DIGITS * 4;

    generate
        if (DIGITS * 4 < DW) begin : g_bad_dw
            $error("cr_gen_fifo_disp: DIGITS*4 must be >= DW");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cr_gen_fifo_disp: DEPTH must be a power of 2, >= 2");
        end
        if (TICK_DIV < 2 || SCAN_DIV < 1) begin : g_bad_div
            $error("cr_gen_fifo_disp: TICK_DIV >= 2, SCAN_DIV >= 1");
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("cr_gen_fifo_disp: DIGITS must be 1..8");
        end
    endgenerate

    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     usedw_q, usedw_d;
    logic [DW-1:0]   gen_val_q, gen_val_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];
    logic [6:0]      ss_q, ss_d;
    logic [DIGITS:1] dig_q, dig_d;

    logic            tick, full, empty;
    logic            rd_acc, wr_acc, scan_wrap;
    logic [NW-1:0]   disp_word;
    logic [3:0]      nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign full      = (usedw_q == (AW + 1)'(DEPTH));
    assign empty     = (usedw_q == '0);
    assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign scan_wrap = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign rd_acc    = tick & bus.ENraf & ~empty;
    assign wr_acc    = bus.ENgen & (~full | rd_acc);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        gen_val_d  = gen_val_q;
        usedw_d    = usedw_q;
        rd_data_d  = rd_data_q;
        mem_d      = mem_q;

        if (wr_acc) begin
            mem_d[wr_ptr_q] = gen_val_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            gen_val_d       = gen_val_q + 1'b1;
        end
        if (rd_acc) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase
    end

    // ss is decoded from next-state rd_data/idx so ss and dig switch together
    always_comb begin
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        disp_word           = '0;
        disp_word[DW-1:0]   = rd_data_d;
        nib                 = disp_word[4 * int'(idx_d) +: 4];
        ss_d                = hex7(nib);
        for (int i = 0; i < DIGITS; i++) begin
            dig_d[i + 1] = (idx_d != IW'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            gen_val_q  <= '0;
            rd_data_q  <= '0;
            ss_q       <= 7'b1000000;
            dig_q      <= {{(DIGITS - 1){1'b1}}, 1'b0};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usedw_q    <= usedw_d;
            gen_val_q  <= gen_val_d;
            rd_data_q  <= rd_data_d;
            ss_q       <= ss_d;
            dig_q      <= dig_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef CR_OVF_LATCH_EN
    logic ovf_q, ovf_d;

    // a write attempt that finds no free slot latches until reset
    always_comb begin
        ovf_d = ovf_q | (bus.ENgen & full & ~rd_acc);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.usedw   = usedw_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.rd_data = rd_data_q;
    assign bus.ss      = ss_q;
    assign bus.dig     = dig_q;
endmodule

// File: tb/tb_cr_gen_fifo_disp.sv
// Directed bench for cr_gen_fifo_disp (DW=8, DEPTH=4, TICK_DIV=4,
// SCAN_DIV=2, DIGITS=4); ovf expectation follows CR_OVF_LATCH_EN.
module tb_cr_gen_fifo_disp;
    logic CLK;
    logic RST;
    int   errs;
    int   total;
    int   cyc;

`ifdef CR_OVF_LATCH_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    cr_gen_fifo_disp_if #(.DW(8), .DEPTH(4), .DIGITS(4)) bus ();

    cr_gen_fifo_disp #(
        .DW(8), .DEPTH(4), .TICK_DIV(4), .SCAN_DIV(2), .DIGITS(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic to_tick();
        do step(); while ((cyc % 4) != 3);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_usedw"}, 32'(bus.usedw), 0);
        chk({tag, "_full"}, 32'(bus.full), 0);
        chk({tag, "_empty"}, 32'(bus.empty), 1);
        chk({tag, "_rd"}, 32'(bus.rd_data), 0);
        chk({tag, "_ovf"}, 32'(bus.ovf), 0);
        chk({tag, "_dig"}, 32'(bus.dig), 32'b1110);
        chk({tag, "_ss"}, 32'(bus.ss), 32'b1000000);
    endtask

    logic [3:0] dig_exp [4];
    logic [6:0] ss_exp  [4];
    int         idx;

    initial begin
        errs  = 0;
        total = 0;
        cyc   = -1;
        dig_exp[0] = 4'b1110; dig_exp[1] = 4'b1101;
        dig_exp[2] = 4'b1011; dig_exp[3] = 4'b0111;
        ss_exp[0]  = 7'b0010010; ss_exp[1] = 7'b0001000;
        ss_exp[2]  = 7'b1000000; ss_exp[3] = 7'b1000000;

        RST = 1'b1;
        bus.ENgen = 1'b0;
        bus.ENraf = 1'b0;
        #1 RST = 1'b0;
        #1 chk_reset("rst");

        // fill from empty: one write per edge, no reads
        #20;
        RST = 1'b1;
        bus.ENgen = 1'b1;
        cyc = -1;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("fill_usedw", 32'(bus.usedw), 32'(n));
        end
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_ovf0", 32'(bus.ovf), 0);
        step();
        chk("stall_usedw", 32'(bus.usedw), 4);
        chk("ovf_set", 32'(bus.ovf), 32'(OVF_EN));

        // pop while full with generator on: usedw pinned at DEPTH
        bus.ENraf = 1'b1;
        for (int n = 0; n < 4; n++) begin
            to_tick();
            chk("pop_full_rd", 32'(bus.rd_data), 32'(n));
            chk("pop_full_usedw", 32'(bus.usedw), 4);
            if (n == 0) begin
                step();
                chk("rd_hold", 32'(bus.rd_data), 0);
            end
        end

        // drain with generator off; pushes 4..7 come out in order
        bus.ENgen = 1'b0;
        for (int n = 4; n < 8; n++) begin
            to_tick();
            chk("drain_rd", 32'(bus.rd_data), 32'(n));
            chk("drain_usedw", 32'(bus.usedw), 32'(7 - n));
        end
        chk("drain_empty", 32'(bus.empty), 1);
        to_tick();
        chk("empty_tick_rd", 32'(bus.rd_data), 7);
        chk("empty_tick_usedw", 32'(bus.usedw), 0);
        chk("ovf_sticky", 32'(bus.ovf), 32'(OVF_EN));

        // async reset pulse between edges while filling
        bus.ENgen = 1'b1;
        bus.ENraf = 1'b0;
        step();
        step();
        chk("refill_usedw", 32'(bus.usedw), 2);
        #3 RST = 1'b0;
        #1 chk_reset("midrst");
        #1;
        RST = 1'b1;
        bus.ENraf = 1'b1;
        cyc = -1;

        // continuous stream: pop n appears after tick n
        for (int n = 0; n <= 165; n++) begin
            to_tick();
            if (n == 0) chk("post_rst_first", 32'(bus.rd_data), 0);
            if (n == 1) chk("post_rst_second", 32'(bus.rd_data), 1);
            if (n == 165) chk("stream_a5", 32'(bus.rd_data), 32'hA5);
        end
        bus.ENraf = 1'b0;
        bus.ENgen = 1'b0;

        // display scan of 8'hA5, two cycles per digit
        for (int k = 0; k < 8; k++) begin
            step();
            idx = ((cyc + 1) / 2) % 4;
            chk("scan_dig", 32'(bus.dig), 32'(dig_exp[idx]));
            chk("scan_ss", 32'(bus.ss), 32'(ss_exp[idx]));
        end

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule
